// File: rtl/placement_pkg.sv
// Shared constants, types and helpers for the placer and the placement evaluator.
package placement_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned N0     = 4;
  localparam int unsigned N      = N0 * N0;
  localparam int unsigned N_EDGE = 15;
  localparam int unsigned N_NODE = 14;

  localparam logic signed [DW-1:0] UNPLACED = -32'sd1;
  localparam logic signed [DW-1:0] N_S      = DW'(N);

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNPLACED = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_OVERLAP  = 2'd3
  } err_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_EDGE = 3'd1,
    RD_A    = 3'd2,
    RD_B    = 3'd3,
    ACC     = 3'd4,
    FIN     = 3'd5
  } state_t;

  // Absolute difference; wraps silently, legal coordinates never get close.
  function automatic logic signed [DW-1:0] abs_diff(input logic signed [DW-1:0] x,
                                                    input logic signed [DW-1:0] y);
    logic signed [DW-1:0] t;
    t = x - y;
    return (t < 0) ? -t : t;
  endfunction

  // Legal coordinate on one axis: 0..N-1.
  function automatic logic in_range(input logic signed [DW-1:0] c);
    return (c >= 0) && (c < N_S);
  endfunction

endpackage

// File: rtl/placement_eval_if.sv
// Edge ROM and position RAM read ports seen by the evaluator.
interface placement_eval_if;
  logic                                  ea_re;
  logic                                  eb_re;
  logic        [placement_pkg::DW-1:0]   ea_addr;
  logic        [placement_pkg::DW-1:0]   eb_addr;
  logic        [placement_pkg::DW-1:0]   ea_dout;
  logic        [placement_pkg::DW-1:0]   eb_dout;
  logic                                  px_re;
  logic                                  py_re;
  logic        [placement_pkg::DW-1:0]   px_addr;
  logic        [placement_pkg::DW-1:0]   py_addr;
  logic signed [placement_pkg::DW-1:0]   px_dout;
  logic signed [placement_pkg::DW-1:0]   py_dout;

  modport master (
    output ea_re, eb_re, ea_addr, eb_addr, px_re, py_re, px_addr, py_addr,
    input  ea_dout, eb_dout, px_dout, py_dout
  );

  modport slave (
    input  ea_re, eb_re, ea_addr, eb_addr, px_re, py_re, px_addr, py_addr,
    output ea_dout, eb_dout, px_dout, py_dout
  );
endinterface

// File: rtl/placement_eval_manhattan_dist.sv
// Manhattan distance between two placed nodes plus legality flags.
module manhattan_dist
  import placement_pkg::*;
(
  input  logic signed [DW-1:0] ax,
  input  logic signed [DW-1:0] ay,
  input  logic signed [DW-1:0] bx,
  input  logic signed [DW-1:0] by,
  output logic signed [DW-1:0] d,
  output logic                 unplaced,
  output logic                 out_of_range,
  output logic                 overlap
);

  // Pure combinational distance and endpoint checks.
  always_comb begin
    d            = abs_diff(ax, bx) + abs_diff(ay, by);
    unplaced     = (ax == UNPLACED) || (ay == UNPLACED) ||
                   (bx == UNPLACED) || (by == UNPLACED);
    out_of_range = !in_range(ax) || !in_range(ay) || !in_range(bx) || !in_range(by);
    overlap      = (ax == bx) && (ay == by);
  end

endmodule

// File: rtl/placement_eval.sv
// Post-placement wirelength evaluator: walks every edge, sums |dx|+|dy|-1,
// tracks the longest edge and stops at the first illegal endpoint pair.
module placement_eval
  import placement_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  placement_eval_if.master     mem,
  output logic signed [DW-1:0] sum,
  output logic        [DW-1:0] max_len,
  output err_t                 err_code,
  output logic        [DW-1:0] err_edge
);

  state_t               state, state_n;
  logic        [DW-1:0] i_q;
  logic        [DW-1:0] b_q;
  logic signed [DW-1:0] ax_q, ay_q;
  logic signed [DW-1:0] d;
  logic                 unplaced, out_of_range, overlap;
  err_t                 acc_err;

  // B endpoint coordinates are consumed straight off the RAM outputs in ACC.
  manhattan_dist u_dist (
    .ax           (ax_q),
    .ay           (ay_q),
    .bx           (mem.px_dout),
    .by           (mem.py_dout),
    .d            (d),
    .unplaced     (unplaced),
    .out_of_range (out_of_range),
    .overlap      (overlap)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, error priority and memory read requests.
  always_comb begin
    state_n     = state;
    mem.ea_re   = 1'b0;
    mem.eb_re   = 1'b0;
    mem.ea_addr = '0;
    mem.eb_addr = '0;
    mem.px_re   = 1'b0;
    mem.py_re   = 1'b0;
    mem.px_addr = '0;
    mem.py_addr = '0;

    if      (unplaced)     acc_err = ERR_UNPLACED;
    else if (out_of_range) acc_err = ERR_RANGE;
    else if (overlap)      acc_err = ERR_OVERLAP;
    else                   acc_err = ERR_NONE;

    case (state)
      IDLE: if (start) state_n = RD_EDGE;
      RD_EDGE: begin
        mem.ea_re   = 1'b1;
        mem.eb_re   = 1'b1;
        mem.ea_addr = i_q;
        mem.eb_addr = i_q;
        state_n     = RD_A;
      end
      RD_A: begin
        mem.px_re   = 1'b1;
        mem.py_re   = 1'b1;
        mem.px_addr = mem.ea_dout;
        mem.py_addr = mem.ea_dout;
        state_n     = RD_B;
      end
      RD_B: begin
        mem.px_re   = 1'b1;
        mem.py_re   = 1'b1;
        mem.px_addr = b_q;
        mem.py_addr = b_q;
        state_n     = ACC;
      end
      ACC: begin
        if (acc_err != ERR_NONE || i_q == DW'(N_EDGE - 1)) state_n = FIN;
        else                                                state_n = RD_EDGE;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath, results and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      i_q      <= '0;
      b_q      <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      sum      <= '0;
      max_len  <= '0;
      err_code <= ERR_NONE;
      err_edge <= '0;
    end else begin
      busy <= (state_n == RD_EDGE) || (state_n == RD_A) ||
              (state_n == RD_B)    || (state_n == ACC);
      done <= (state_n == FIN);
      case (state)
        IDLE: if (start) begin
          i_q      <= '0;
          sum      <= '0;
          max_len  <= '0;
          err_code <= ERR_NONE;
          err_edge <= '0;
        end
        RD_A: b_q <= mem.eb_dout;
        RD_B: begin
          ax_q <= mem.px_dout;
          ay_q <= mem.py_dout;
        end
        ACC: begin
          if (acc_err != ERR_NONE) begin
            err_code <= acc_err;
            err_edge <= i_q;
          end else begin
            sum <= sum + d - 32'sd1;
            if ($unsigned(d) > max_len) max_len <= $unsigned(d);
            i_q <= i_q + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_placement_eval.sv
// Directed scoreboard bench for placement_eval with behavioural ROM/RAM models.
module tb_placement_eval;
  import placement_pkg::*;

  typedef struct {
    logic signed [31:0] sum;
    logic        [31:0] max_len;
    err_t               err;
    logic        [31:0] edge_idx;
    int                 lat;
    int                 t0;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               busy, done;
  logic signed [31:0] sum;
  logic        [31:0] max_len;
  err_t               err_code;
  logic        [31:0] err_edge;

  placement_eval_if m ();

  placement_eval dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem      (m),
    .sum      (sum),
    .max_len  (max_len),
    .err_code (err_code),
    .err_edge (err_edge)
  );

  always #5 clk = ~clk;

  logic        [31:0] ea_mem [0:15];
  logic        [31:0] eb_mem [0:15];
  logic signed [31:0] px_mem [0:15];
  logic signed [31:0] py_mem [0:15];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle registered read memories.
  always @(posedge clk) begin
    if (m.ea_re) m.ea_dout <= ea_mem[m.ea_addr[3:0]];
    if (m.eb_re) m.eb_dout <= eb_mem[m.eb_addr[3:0]];
    if (m.px_re) m.px_dout <= px_mem[m.px_addr[3:0]];
    if (m.py_re) m.py_dout <= py_mem[m.py_addr[3:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Monitor: compare each done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum",      sum,                e.sum);
        chk("max_len",  max_len,            e.max_len);
        chk("err_code", 32'(err_code),      32'(e.err));
        chk("err_edge", err_edge,           e.edge_idx);
        chk("latency",  32'(cyc - e.t0),    32'(e.lat));
      end
    end
  end

  // Base layout: node k at (k,0); chain edges plus 13-0 and 0-2.
  task automatic base_layout();
    for (int k = 0; k < 16; k++) begin
      px_mem[k] = 32'(k);
      py_mem[k] = 0;
      ea_mem[k] = 0;
      eb_mem[k] = 0;
    end
    for (int k = 0; k < 13; k++) begin
      ea_mem[k] = 32'(k);
      eb_mem[k] = 32'(k + 1);
    end
    ea_mem[13] = 13; eb_mem[13] = 0;
    ea_mem[14] = 0;  eb_mem[14] = 2;
  endtask

  // Node 1 at (3,2), node 13 at (13,15).
  task automatic layout2();
    base_layout();
    px_mem[1]  = 3;
    py_mem[1]  = 2;
    py_mem[13] = 15;
  endtask

  function automatic exp_t mk(input int s, input int mx, input err_t e, input int ed, input int lat);
    exp_t r;
    r.sum = 32'(s); r.max_len = 32'(mx); r.err = e; r.edge_idx = 32'(ed); r.lat = lat; r.t0 = 0;
    return r;
  endfunction

  // Issue one evaluation; optionally re-pulse start mid-run at cycle offset extra.
  task automatic run(input exp_t e, input int extra);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    e.t0 = cyc;
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 200; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = (extra != 0 && k == extra);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    if (!seen) q.delete();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    m.ea_dout = '0; m.eb_dout = '0; m.px_dout = '0; m.py_dout = '0;
    base_layout();
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  sum,       32'd0);
    chk("rst_ea_re", 32'(m.ea_re), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Clean run over all 15 edges.
    base_layout();
    run(mk(13, 13, ERR_NONE, 0, 61), 0);
    repeat (4) @(negedge clk);
    chk("hold_sum", sum, 32'd13);
    chk("hold_max", max_len, 32'd13);

    // Longer edges, including a coordinate of N-1.
    layout2();
    run(mk(49, 28, ERR_NONE, 0, 61), 0);

    // Unplaced endpoint on edge 2, partial sum of edges 0-1.
    layout2();
    px_mem[3] = -1;
    run(mk(6, 5, ERR_UNPLACED, 2, 13), 0);

    // Overlap: nodes 6 and 7 both at (5,5).
    base_layout();
    px_mem[6] = 5; py_mem[6] = 5;
    px_mem[7] = 5; py_mem[7] = 5;
    run(mk(4, 5, ERR_OVERLAP, 6, 29), 0);

    // Coordinate 16 is out of range.
    base_layout();
    py_mem[9] = 16;
    run(mk(0, 1, ERR_RANGE, 8, 37), 0);

    // Unplaced outranks range on the same node.
    base_layout();
    px_mem[10] = -5; py_mem[10] = -1;
    run(mk(0, 1, ERR_UNPLACED, 9, 41), 0);

    // Negative coordinate other than -1 is a range error.
    base_layout();
    px_mem[10] = -5;
    run(mk(0, 1, ERR_RANGE, 9, 41), 0);

    // Self-loop on an out-of-range node: range outranks overlap, first edge.
    base_layout();
    ea_mem[0] = 5; eb_mem[0] = 5; px_mem[5] = 16;
    run(mk(0, 0, ERR_RANGE, 0, 5), 0);

    // Start re-pulsed mid-run is ignored.
    base_layout();
    run(mk(13, 13, ERR_NONE, 0, 61), 20);

    // Async reset mid-run, then a fresh evaluation.
    layout2();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_sum",  sum,       32'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_sum",  sum,           32'd0);
    chk("mid_rst_max",  max_len,       32'd0);
    chk("mid_rst_err",  32'(err_code), 32'd0);
    chk("mid_rst_edge", err_edge,      32'd0);
    chk("mid_rst_busy", 32'(busy),     32'd0);
    chk("mid_rst_px",   m.px_addr | m.ea_addr | 32'(m.px_re) | 32'(m.ea_re), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(mk(49, 28, ERR_NONE, 0, 61), 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/placement_eval.md
Name: placement_eval

Overview:
- Post-placement wirelength evaluator. Sits directly downstream of the placement stage.
- After placement has filled the pos_X/pos_Y RAMs, this block walks the edge ROMs (e_a/e_b) and reads both endpoint coordinates for every edge.
- Accumulates total cost sum(|dx|+|dy|-1), tracks the longest edge, and flags illegal placements.
- Evaluation is moved out of the placer FSM; the results feed the host/testbench.

Parameters:
- N0, 4, grid base; axis size N = N0*N0, legal coordinates 0..N-1.
- N_EDGE, 15, number of edges in e_a/e_b.
- N_NODE, 14, number of nodes (pos RAM depth).
- DW, 32, data width of all memories and results.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin evaluation.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when evaluation ends (normally or on error).
- ea_re / eb_re  out  1  edge ROM read enables.
- ea_addr / eb_addr  out  32  edge index.
- ea_dout / eb_dout  in  32  node ids; valid the cycle after re.
- px_re / py_re  out  1  position RAM read enables (this block never writes).
- px_addr / py_addr  out  32  node id.
- px_dout / py_dout  in  32 signed  coordinates; -1 means unplaced; valid the cycle after re.
- sum  out  32 signed  total cost.
- max_len  out  32  largest |dx|+|dy| over all evaluated edges.
- err_code  out  2  0 = ok, 1 = unplaced endpoint, 2 = coordinate out of range, 3 = overlapping endpoints.
- err_edge  out  32  index of the edge that caused the error; 0 when err_code = 0.

Behaviour:
- Reset (async, any state, including mid-run):
  - State = IDLE.
  - busy, done, all re = 0; all addr = 0.
  - sum, max_len, err_edge = 0; err_code = 0.
- Memories have 1-cycle registered read: address and re are presented in cycle t, data is sampled in cycle t+1.
- FSM states: IDLE, RD_EDGE, RD_A, RD_B, ACC, FIN.
  - IDLE: on start, clear sum/max_len/err_code/err_edge, set i = 0 and busy = 1 -> RD_EDGE. Otherwise hold all results.
  - RD_EDGE: ea_re = eb_re = 1, ea_addr = eb_addr = i -> RD_A.
  - RD_A: latch a = ea_dout, b = eb_dout; px_re = py_re = 1, addr = ea_dout (use the dout directly, not the register) -> RD_B.
  - RD_B: latch ax = px_dout, ay = py_dout; issue px/py read at b -> ACC.
  - ACC: latch bx, by; compute checks and cost in priority order (see below) -> FIN on error, otherwise -> RD_EDGE with i+1, or -> FIN when i == N_EDGE-1.
  - FIN: done = 1 for exactly one cycle, busy = 0 -> IDLE.
- ACC checks, in priority order:
  1. Any coordinate == -1 -> err_code = 1.
  2. Any coordinate < 0 or >= N -> err_code = 2.
  3. ax == bx and ay == by -> err_code = 3.
  - On error: err_edge = i, sum/max_len keep their partial values.
- ACC arithmetic when no error:
  - d = |ax-bx| + |ay-by|, 32-bit signed, no saturation; wrap is acceptable because legal range keeps d <= 2N-2.
  - sum += d-1.
  - max_len = max(max_len, d).
- Timing: 4 cycles per edge. Clean run: done asserts exactly 4*N_EDGE+1 cycles after the start cycle.
- re signals are high only in their issue cycle; otherwise 0.
- start while busy (any non-IDLE state) is ignored.
- start in the same cycle as done cannot occur, since done only asserts in FIN; start is accepted in the following IDLE cycle.
- Results remain stable after done until the next accepted start.

Decomposition:
- Shared package placement_pkg:
  - Constants N0, N, N_EDGE, N_NODE.
  - UNPLACED = -1.
  - err_code enum ERR_NONE/ERR_UNPLACED/ERR_RANGE/ERR_OVERLAP.
  - FSM state typedef.
  - The placer shares this package.
- One natural sub-module: manhattan_dist. Combinational, takes (ax, ay, bx, by), outputs d plus the range, overlap and unplaced flags; unit-tested standalone.

Test Plan:
- Chain 0-1-2 at (0,0),(0,1),(1,1), N_EDGE=2, start -> done at cycle 9; sum=0, max_len=1, err_code=0.
- Edge 0-1 with nodes at (0,0),(3,2), N_EDGE=1 -> sum=4, max_len=5, done after 5 cycles.
- Edge 2 with endpoint pos_X = -1 -> done early; err_code=1, err_edge=2, sum equals partial over edges 0-1.
- Endpoints both at (5,5) -> err_code=3. Coordinate 16 with N0=4 -> err_code=2.
- start pulsed again mid-run -> ignored, same results and timing. reset asserted at edge 3 -> outputs zero immediately (async), busy=0, next start re-evaluates from edge 0.
